// File: rtl/tmr_fault_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module : tmr_fault_manager_pkg
// Brief  : Shared state encoding, replica indices and helpers for the TMR
//          fault manager.
// Rev    : 1.0  initial release
// ============================================================================
package tmr_fault_manager_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_RECOVER = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_FATAL   = 2'd3
  } tmr_state_e;

  localparam int unsigned c_NUM_REPLICAS = 3;
  localparam logic [1:0]  c_IDX_A        = 2'd0;
  localparam logic [1:0]  c_IDX_B        = 2'd1;
  localparam logic [1:0]  c_IDX_C        = 2'd2;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [1:0] lowest_index(input logic [2:0] v);
    logic [1:0] idx;
    idx = c_IDX_A;
    if (v[0])      idx = c_IDX_A;
    else if (v[1]) idx = c_IDX_B;
    else if (v[2]) idx = c_IDX_C;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_fault_manager_voter.sv
`default_nettype none
// ============================================================================
// Module : tmr_fault_manager_voter
// Brief  : Combinational masked majority voter with per-replica mismatch
//          vector and no-trustworthy-majority flag.
// Rev    : 1.0  initial release
// ============================================================================
module tmr_fault_manager_voter
  import tmr_fault_manager_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_result_a,
  input  logic [WIDTH-1:0] i_result_b,
  input  logic [WIDTH-1:0] i_result_c,
  input  logic [2:0]       i_mask,
  output logic [WIDTH-1:0] o_voted,
  output logic [WIDTH-1:0] o_raw_majority,
  output logic [2:0]       o_mismatch,
  output logic             o_no_majority
);

  logic [WIDTH-1:0] w_majority;
  logic             w_ab_eq;
  logic             w_bc_eq;
  logic             w_ac_eq;

  assign w_majority = (i_result_a & i_result_b) | (i_result_a & i_result_c) |
                      (i_result_b & i_result_c);
  assign w_ab_eq    = (i_result_a == i_result_b);
  assign w_bc_eq    = (i_result_b == i_result_c);
  assign w_ac_eq    = (i_result_a == i_result_c);

  assign o_raw_majority = w_majority;

  // With one replica masked the two survivors must agree; the lower index wins.
  always_comb begin
    o_voted       = w_majority;
    o_no_majority = !w_ab_eq && !w_bc_eq && !w_ac_eq;
    case (i_mask)
      3'b001: begin
        o_voted       = i_result_b;
        o_no_majority = !w_bc_eq;
      end
      3'b010: begin
        o_voted       = i_result_a;
        o_no_majority = !w_ac_eq;
      end
      3'b100: begin
        o_voted       = i_result_a;
        o_no_majority = !w_ab_eq;
      end
      default: ;
    endcase
  end

  assign o_mismatch[0] = (i_result_a != o_voted);
  assign o_mismatch[1] = (i_result_b != o_voted);
  assign o_mismatch[2] = (i_result_c != o_voted);

endmodule
`default_nettype wire

// File: rtl/tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module : tmr_fault_manager
// Brief  : Votes three replica results, masks a persistently faulty replica,
//          sequences its resync handshake and escalates to sticky FATAL.
// Rev    : 1.0  initial release
// ============================================================================
module tmr_fault_manager
  import tmr_fault_manager_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int ERR_THRESH     = 4,
  parameter int RECOVER_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] result_a_i,
  input  logic [WIDTH-1:0] result_b_i,
  input  logic [WIDTH-1:0] result_c_i,
  input  logic             recover_ack_i,
  output logic [WIDTH-1:0] voted_o,
  output logic             voted_valid_o,
  output logic [2:0]       mismatch_o,
  output logic [2:0]       replica_mask_o,
  output logic             recover_req_o,
  output logic [1:0]       recover_id_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [1:0]       state_o
);

  localparam int c_ERR_CW    = $clog2(ERR_THRESH + 1);
  localparam int c_SETTLE_CW = $clog2(RECOVER_CYCLES + 1);

  localparam logic [c_ERR_CW-1:0]    c_ERR_LIMIT    = c_ERR_CW'(ERR_THRESH);
  localparam logic [c_SETTLE_CW-1:0] c_SETTLE_LIMIT = c_SETTLE_CW'(RECOVER_CYCLES);

  tmr_state_e                    r_state,  w_state_next;
  logic [2:0]                    r_mask,   w_mask_next;
  logic                          r_req,    w_req_next;
  logic [1:0]                    r_id,     w_id_next;
  logic [2:0][c_ERR_CW-1:0]      r_cnt,    w_cnt_next;
  logic [c_SETTLE_CW-1:0]        r_settle, w_settle_next;
  logic [c_SETTLE_CW-1:0]        w_settle_inc;

  logic [WIDTH-1:0]              r_voted;
  logic                          r_voted_valid;
  logic [2:0]                    r_mismatch;
  logic [CNT_W-1:0]              r_err_count;

  logic [WIDTH-1:0]              w_voted;
  logic [WIDTH-1:0]              w_raw_majority;
  logic [WIDTH-1:0]              w_voted_out;
  logic [2:0]                    w_mismatch;
  logic                          w_no_majority;
  logic [2:0]                    w_unmasked_mis;
  logic [2:0][c_ERR_CW-1:0]      w_cnt_upd;
  logic [2:0]                    w_hit;
  logic [1:0]                    w_hit_count;

  tmr_fault_manager_voter #(
    .WIDTH (WIDTH)
  ) u_voter (
    .i_result_a     (result_a_i),
    .i_result_b     (result_b_i),
    .i_result_c     (result_c_i),
    .i_mask         (r_mask),
    .o_voted        (w_voted),
    .o_raw_majority (w_raw_majority),
    .o_mismatch     (w_mismatch),
    .o_no_majority  (w_no_majority)
  );

  assign w_unmasked_mis = w_mismatch & ~r_mask;
  assign w_voted_out    = (r_state == ST_FATAL) ? w_raw_majority : w_voted;
  assign w_settle_inc   = r_settle + 1'b1;

  // Masked replicas keep their count; it is wiped when the replica rejoins.
  for (genvar gi = 0; gi < int'(c_NUM_REPLICAS); gi++) begin : g_replica_cnt
    always_comb begin
      w_cnt_upd[gi] = r_cnt[gi];
      if (!r_mask[gi]) begin
        if (w_mismatch[gi]) begin
          if (r_cnt[gi] != c_ERR_LIMIT) w_cnt_upd[gi] = r_cnt[gi] + 1'b1;
        end else begin
          w_cnt_upd[gi] = '0;
        end
      end
    end
    assign w_hit[gi] = !r_mask[gi] && (w_cnt_upd[gi] == c_ERR_LIMIT);
  end

  assign w_hit_count = popcount3(w_hit);

  always_comb begin
    w_state_next  = r_state;
    w_mask_next   = r_mask;
    w_req_next    = r_req;
    w_id_next     = r_id;
    w_cnt_next    = r_cnt;
    w_settle_next = r_settle;

    case (r_state)
      ST_RUN: begin
        if (valid_i) begin
          w_cnt_next = w_cnt_upd;
          if (w_no_majority || (w_hit_count >= 2'd2)) begin
            w_state_next = ST_FATAL;
          end else if (w_hit_count == 2'd1) begin
            w_mask_next  = w_hit;
            w_id_next    = lowest_index(w_hit);
            w_req_next   = 1'b1;
            w_state_next = ST_RECOVER;
          end
        end
      end
      ST_RECOVER: begin
        if (valid_i) w_cnt_next = w_cnt_upd;
        if (valid_i && w_no_majority) begin
          w_state_next = ST_FATAL;
        end else if (recover_ack_i) begin
          w_req_next    = 1'b0;
          w_settle_next = '0;
          w_state_next  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (valid_i) begin
          w_cnt_next = w_cnt_upd;
          if (w_no_majority) begin
            w_state_next = ST_FATAL;
          end else if ((w_mismatch & r_mask) != 3'b000) begin
            w_settle_next = '0;
            w_req_next    = 1'b1;
            w_state_next  = ST_RECOVER;
          end else if (w_settle_inc == c_SETTLE_LIMIT) begin
            w_settle_next = '0;
            w_mask_next   = 3'b000;
            w_cnt_next    = '0;
            w_state_next  = ST_RUN;
          end else begin
            w_settle_next = w_settle_inc;
          end
        end
      end
      default: ;
    endcase

    if (w_state_next == ST_FATAL) begin
      w_mask_next = 3'b000;
      w_req_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_RUN;
      r_mask   <= 3'b000;
      r_req    <= 1'b0;
      r_id     <= c_IDX_A;
      r_cnt    <= '0;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_next;
      r_mask   <= w_mask_next;
      r_req    <= w_req_next;
      r_id     <= w_id_next;
      r_cnt    <= w_cnt_next;
      r_settle <= w_settle_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_voted       <= '0;
      r_voted_valid <= 1'b0;
      r_mismatch    <= 3'b000;
      r_err_count   <= '0;
    end else begin
      r_voted_valid <= valid_i;
      r_mismatch    <= valid_i ? w_mismatch : 3'b000;
      if (valid_i) begin
        r_voted <= w_voted_out;
        if ((popcount3(w_unmasked_mis) == 2'd1) && (r_err_count != {CNT_W{1'b1}}))
          r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign voted_o        = r_voted;
  assign voted_valid_o  = r_voted_valid;
  assign mismatch_o     = r_mismatch;
  assign replica_mask_o = r_mask;
  assign recover_req_o  = r_req;
  assign recover_id_o   = r_id;
  assign fatal_o        = (r_state == ST_FATAL);
  assign err_count_o    = r_err_count;
  assign state_o        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tmr_fault_manager.sv
`default_nettype none
// ============================================================================
// Module : tb_tmr_fault_manager
// Brief  : Scoreboard bench for tmr_fault_manager with directed vectors.
// Rev    : 1.0  initial release
// ============================================================================
module tb_tmr_fault_manager;

  typedef struct packed {
    logic [31:0] voted;
    logic [2:0]  mis;
    logic [2:0]  mask;
    logic        req;
    logic [1:0]  id;
    logic        fatal;
    logic [7:0]  err;
    logic [1:0]  state;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic [31:0] result_a_i, result_b_i, result_c_i;
  logic        recover_ack_i;
  logic [31:0] voted_o;
  logic        voted_valid_o;
  logic [2:0]  mismatch_o;
  logic [2:0]  replica_mask_o;
  logic        recover_req_o;
  logic [1:0]  recover_id_o;
  logic        fatal_o;
  logic [7:0]  err_count_o;
  logic [1:0]  state_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  tmr_fault_manager #(
    .WIDTH(32), .ERR_THRESH(4), .RECOVER_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i),
    .result_a_i(result_a_i), .result_b_i(result_b_i), .result_c_i(result_c_i),
    .recover_ack_i(recover_ack_i), .voted_o(voted_o), .voted_valid_o(voted_valid_o),
    .mismatch_o(mismatch_o), .replica_mask_o(replica_mask_o),
    .recover_req_o(recover_req_o), .recover_id_o(recover_id_o), .fatal_o(fatal_o),
    .err_count_o(err_count_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] v, input logic [2:0] mis, input logic [2:0] mask,
                              input logic req, input logic [1:0] id, input logic fatal,
                              input logic [7:0] err, input logic [1:0] st);
    exp_t e;
    e.voted = v; e.mis = mis; e.mask = mask; e.req = req; e.id = id;
    e.fatal = fatal; e.err = err; e.state = st;
    return e;
  endfunction

  task automatic sample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input exp_t e);
    @(negedge clk);
    valid_i = 1'b1; result_a_i = a; result_b_i = b; result_c_i = c;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  task automatic ack_pulse();
    recover_ack_i = 1'b1;
    @(negedge clk);
    recover_ack_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".voted"}, voted_o, 32'h0);
    chk({tag, ".valid"}, {31'h0, voted_valid_o}, 32'h0);
    chk({tag, ".mis"}, {29'h0, mismatch_o}, 32'h0);
    chk({tag, ".mask"}, {29'h0, replica_mask_o}, 32'h0);
    chk({tag, ".req"}, {31'h0, recover_req_o}, 32'h0);
    chk({tag, ".id"}, {30'h0, recover_id_o}, 32'h0);
    chk({tag, ".fatal"}, {31'h0, fatal_o}, 32'h0);
    chk({tag, ".err"}, {24'h0, err_count_o}, 32'h0);
    chk({tag, ".state"}, {30'h0, state_o}, 32'h0);
  endtask

  // Monitor: pops one expectation per voted_valid_o pulse.
  always @(negedge clk) begin
    if (reset_n && voted_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got voted 0x%0h expected no output", voted_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("voted", voted_o, e.voted);
        chk("mismatch", {29'h0, mismatch_o}, {29'h0, e.mis});
        chk("mask", {29'h0, replica_mask_o}, {29'h0, e.mask});
        chk("req", {31'h0, recover_req_o}, {31'h0, e.req});
        chk("id", {30'h0, recover_id_o}, {30'h0, e.id});
        chk("fatal", {31'h0, fatal_o}, {31'h0, e.fatal});
        chk("err_count", {24'h0, err_count_o}, {24'h0, e.err});
        chk("state", {30'h0, state_o}, {30'h0, e.state});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; valid_i = 1'b0; recover_ack_i = 1'b0;
    result_a_i = '0; result_b_i = '0; result_c_i = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Clean agreement
    for (int k = 0; k < 10; k++)
      sample(32'h12345678, 32'h12345678, 32'h12345678,
             mk(32'h12345678, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 8'd0, 2'd0));

    // Replica B persistently wrong until it is masked
    for (int k = 1; k <= 4; k++)
      sample(32'h1, 32'hDEADBEEF, 32'h1,
             mk(32'h1, 3'b010, (k == 4) ? 3'b010 : 3'b000, k == 4, (k == 4) ? 2'd1 : 2'd0,
                1'b0, 8'(k), (k == 4) ? 2'd1 : 2'd0));

    // Request held while ack is low
    idle(1);
    for (int k = 0; k < 20; k++) begin
      chk("req_hold", {31'h0, recover_req_o}, 32'h1);
      @(negedge clk);
    end
    ack_pulse();
    chk("req_after_ack", {31'h0, recover_req_o}, 32'h0);
    chk("state_settle", {30'h0, state_o}, 32'h2);

    // Settle interrupted by B mismatching on the 5th sample
    for (int k = 1; k <= 4; k++)
      sample(32'h1, 32'h1, 32'h1, mk(32'h1, 3'b000, 3'b010, 1'b0, 2'd1, 1'b0, 8'd4, 2'd2));
    sample(32'h1, 32'hDEADBEEF, 32'h1, mk(32'h1, 3'b010, 3'b010, 1'b1, 2'd1, 1'b0, 8'd4, 2'd1));
    idle(1);
    chk("state_rerecover", {30'h0, state_o}, 32'h1);
    ack_pulse();
    chk("state_settle2", {30'h0, state_o}, 32'h2);

    // Full settle window re-admits B
    for (int k = 1; k <= 16; k++)
      sample(32'h1, 32'h1, 32'h1,
             mk(32'h1, 3'b000, (k == 16) ? 3'b000 : 3'b010, 1'b0, 2'd1, 1'b0, 8'd4,
                (k == 16) ? 2'd0 : 2'd2));
    sample(32'h5, 32'h5, 32'h5, mk(32'h5, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0, 8'd4, 2'd0));
    sample(32'h7, 32'h7, 32'h0, mk(32'h7, 3'b100, 3'b000, 1'b0, 2'd1, 1'b0, 8'd5, 2'd0));

    // No majority -> sticky FATAL
    sample(32'h1, 32'h2, 32'h3, mk(32'h3, 3'b011, 3'b000, 1'b0, 2'd1, 1'b1, 8'd5, 2'd3));
    sample(32'h9, 32'h9, 32'h9, mk(32'h9, 3'b000, 3'b000, 1'b0, 2'd1, 1'b1, 8'd5, 2'd3));
    idle(3);
    chk("fatal_sticky", {31'h0, fatal_o}, 32'h1);

    // Reset clears FATAL, then reset mid-RECOVER
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 4; k++)
      sample(32'h1, 32'hDEADBEEF, 32'h1,
             mk(32'h1, 3'b010, (k == 4) ? 3'b010 : 3'b000, k == 4, (k == 4) ? 2'd1 : 2'd0,
                1'b0, 8'(k), (k == 4) ? 2'd1 : 2'd0));
    idle(3);
    chk("pre_reset_req", {31'h0, recover_req_o}, 32'h1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sample(32'h55, 32'h55, 32'h55, mk(32'h55, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0, 8'd0, 2'd0));
    idle(3);

    chk("scoreboard_empty", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
